lite_v1_issuer: RTL and testbench

//  Instruction issuer for the lite_v1 datapath: fetches 20-bit words from a synchronous

---
 rtl/lite_v1_issuer_pkg.sv | 35 +++
 rtl/lite_v1_issuer.sv | 116 +++++++++++
 tb/tb_lite_v1_issuer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lite_v1_issuer_pkg.sv
// Shared lite_v1 issuer definitions: instruction word layout, opcode codes and FSM states.
package lite_v1_issuer_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned D1_W    = 8;
  localparam int unsigned D2_W    = 10;

  typedef enum logic [OP_W-1:0] {
    OP_D1   = 2'b00,
    OP_D2   = 2'b01,
    OP_CLR  = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  // Field order matches the memory word: [19:18] op, [17:10] d1, [9:0] d2.
  typedef struct packed {
    opcode_e         op;
    logic [D1_W-1:0] d1;
    logic [D2_W-1:0] d2;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic is_halt(input instr_t instr);
    return instr.op == OP_HALT;
  endfunction

endpackage

// File: rtl/lite_v1_issuer.sv
// Instruction issuer: fetch one word, decode it, hold it with valid/ready until accepted.
// One instruction per three cycles with an always-ready consumer; no prefetch.
module lite_v1_issuer
  import lite_v1_issuer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    opcode,
  output logic [D1_W-1:0]    d1,
  output logic [D2_W-1:0]    d2,
  output logic               busy,
  output logic               done,
  output logic               wrap_err,
  output logic [CNT_W-1:0]   issued_cnt
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_rd_en;
  instr_t             r_instr;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap_err;
  logic [CNT_W-1:0]   r_cnt;
  instr_t             w_instr;

  assign w_instr = instr_t'(imem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_rd_en     <= 1'b0;
      r_instr     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap_err  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_FETCH;
            r_pc       <= start_addr;
            r_rd_en    <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_wrap_err <= 1'b0;
            r_cnt      <= '0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_instr <= w_instr;
          if (is_halt(w_instr)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Fields stay frozen until the handshake; the last address ends the run.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (r_pc == PC_LAST) begin
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_wrap_err <= 1'b1;
            end else begin
              r_pc    <= r_pc + ADDR_W'(1);
              r_rd_en <= 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_rd_en = r_rd_en;
  assign imem_addr  = r_pc;
  assign out_valid  = r_out_valid;
  assign opcode     = r_instr.op;
  assign d1         = r_instr.d1;
  assign d2         = r_instr.d2;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wrap_err   = r_wrap_err;
  assign issued_cnt = r_cnt;

endmodule

// File: tb/tb_lite_v1_issuer.sv
// Directed bench for lite_v1_issuer: table of program runs plus reset/start-while-busy sequence.
module tb_lite_v1_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [19:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  opcode;
  logic [7:0]  d1;
  logic [9:0]  d2;
  logic        busy;
  logic        done;
  logic        wrap_err;
  logic [7:0]  issued_cnt;

  logic [19:0] mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    int          stall;
    int          exp_cnt;
    logic        exp_wrap;
    int          exp_lat;
    int          exp_fetch;
    logic [19:0] exp_first;
    logic [19:0] exp_last;
  } run_t;

  run_t runs [5];

  lite_v1_issuer #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .d1         (d1),
    .d2         (d2),
    .busy       (busy),
    .done       (done),
    .wrap_err   (wrap_err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM: data one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},  32'(imem_rd_en), 32'd0);
    chk({tag, "_addr"},   32'(imem_addr),  32'd0);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_fields"}, 32'({opcode, d1, d2}), 32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_done"},   32'(done),       32'd0);
    chk({tag, "_wrap"},   32'(wrap_err),   32'd0);
    chk({tag, "_cnt"},    32'(issued_cnt), 32'd0);
  endtask

  // Pulse start, then watch cycle by cycle until done (bounded).
  task automatic do_run(input int idx, input run_t r);
    int          k;
    int          stall_left;
    int          fetches;
    int          hs;
    int          done_lat;
    bit          got_done;
    bit          prev_stall;
    bit          busy_bad;
    logic [19:0] prev_f;
    logic [19:0] first_f;
    logic [19:0] last_f;
    string       t;
    t          = $sformatf("run%0d", idx);
    stall_left = r.stall;
    fetches    = 0;
    hs         = 0;
    done_lat   = 0;
    got_done   = 1'b0;
    prev_stall = 1'b0;
    busy_bad   = 1'b0;
    prev_f     = '0;
    first_f    = '0;
    last_f     = '0;
    start      = 1'b1;
    start_addr = r.addr;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({t, "_first_rd_en"}, 32'(imem_rd_en), 32'd1);
    chk({t, "_first_addr"},  32'(imem_addr),  32'(r.addr));
    k = 1;
    while (k <= 40 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
        done_lat = k;
      end else begin
        if (!busy) busy_bad = 1'b1;
        if (imem_rd_en) fetches++;
        if (prev_stall) begin
          chk({t, "_stall_valid"}, 32'(out_valid), 32'd1);
          chk({t, "_stall_fields"}, 32'({opcode, d1, d2}), 32'(prev_f));
        end
        prev_stall = 1'b0;
        out_ready  = 1'b1;
        if (out_valid) begin
          if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left--;
            prev_stall = 1'b1;
            prev_f     = {opcode, d1, d2};
          end else begin
            if (hs == 0) first_f = {opcode, d1, d2};
            last_f = {opcode, d1, d2};
            hs++;
          end
        end
        @(posedge clk); #1;
        k++;
      end
    end
    chk({t, "_done_reached"}, 32'(got_done),   32'd1);
    chk({t, "_done_latency"}, 32'(done_lat),   32'(r.exp_lat));
    chk({t, "_busy_in_run"},  32'(busy_bad),   32'd0);
    chk({t, "_busy_at_done"}, 32'(busy),       32'd0);
    chk({t, "_valid_at_done"},32'(out_valid),  32'd0);
    chk({t, "_fetches"},      32'(fetches),    32'(r.exp_fetch));
    chk({t, "_handshakes"},   32'(hs),         32'(r.exp_cnt));
    chk({t, "_issued_cnt"},   32'(issued_cnt), 32'(r.exp_cnt));
    chk({t, "_wrap_err"},     32'(wrap_err),   32'(r.exp_wrap));
    if (r.exp_cnt > 0) begin
      chk({t, "_first_issue"}, 32'(first_f), 32'(r.exp_first));
      chk({t, "_last_issue"},  32'(last_f),  32'(r.exp_last));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {2'b11, 8'h00, 10'h000};
    mem[8'h00] = {2'b00, 8'h11, 10'h000};
    mem[8'h01] = {2'b01, 8'h00, 10'h155};
    mem[8'h02] = {2'b11, 8'h00, 10'h000};
    mem[8'h03] = {2'b10, 8'hAA, 10'h3FF};
    mem[8'h10] = {2'b11, 8'h00, 10'h000};
    mem[8'h20] = {2'b10, 8'h5A, 10'h0A5};
    mem[8'h21] = {2'b00, 8'hC3, 10'h111};
    mem[8'h22] = {2'b11, 8'h00, 10'h000};
    mem[8'hFE] = {2'b00, 8'h7E, 10'h2AA};
    mem[8'hFF] = {2'b01, 8'h81, 10'h155};

    runs[0] = '{8'h00, 0, 2, 1'b0,  9, 3, {2'b00, 8'h11, 10'h000}, {2'b01, 8'h00, 10'h155}};
    runs[1] = '{8'h00, 5, 2, 1'b0, 14, 3, {2'b00, 8'h11, 10'h000}, {2'b01, 8'h00, 10'h155}};
    runs[2] = '{8'h10, 0, 0, 1'b0,  3, 1, 20'h0, 20'h0};
    runs[3] = '{8'hFE, 0, 2, 1'b1,  7, 2, {2'b00, 8'h7E, 10'h2AA}, {2'b01, 8'h81, 10'h155}};
    runs[4] = '{8'h20, 0, 2, 1'b0,  9, 3, {2'b10, 8'h5A, 10'h0A5}, {2'b00, 8'hC3, 10'h111}};

    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 8'h00;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("reset");
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Runs 3->4 are back-to-back: run 4 starts while DONE with wrap_err set.
    for (int i = 0; i < 5; i++) do_run(i, runs[i]);

    // Start while busy is ignored; rst during ISSUE aborts the run.
    start      = 1'b1;
    start_addr = 8'h20;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 8'h55;
    chk("seq_fetch_rd_en", 32'(imem_rd_en), 32'd1);
    chk("seq_fetch_cnt_clr", 32'(issued_cnt), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_rd_en", 32'(imem_rd_en), 32'd0);
    chk("busy_start_addr",  32'(imem_addr),  32'h20);
    chk("busy_start_busy",  32'(busy),       32'd1);
    @(posedge clk); #1;
    chk("seq_issue_valid",  32'(out_valid), 32'd1);
    chk("seq_issue_fields", 32'({opcode, d1, d2}), 32'({2'b10, 8'h5A, 10'h0A5}));
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    chk_all_zero("midrun_rst");
    @(posedge clk); #1;
    chk("post_rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("post_rst_valid", 32'(out_valid),  32'd0);
    chk("post_rst_busy",  32'(busy),       32'd0);

    do_run(5, runs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
